avalon_mem_arbiter: RTL
=======================

// Module: avalon_mem_arbiter
// PURPOSE
//  Two-master to one-slave Avalon-MM arbiter between the MIPS CPU and the unified RAM model.
//  Shares the single memory slave between the instruction-fetch master (read-only) and the
//  data master (read/write, byteenable). Sits between the CPU top level and the RAM in the
//  test bench. Forwards slave waitrequest to the granted master and stalls the other.
// PARAMETERS
//  ADDR_W      32   address width, byte address, passed through unchanged
//  DATA_W      32   data width
//  TIMEOUT     64   max consecutive slave-waitrequest cycles before timeout_err sets
// PORTS
//  clk              in   1       rising-edge clock
//  reset_n          in   1       asynchronous, active-low reset
//  i_address        in   ADDR_W  instr master address
//  i_read           in   1       instr master read request
//  i_readdata       out  DATA_W  instr master read data
//  i_waitrequest    out  1       instr master stall
//  d_address        in   ADDR_W  data master address
//  d_read           in   1       data master read request
//  d_write          in   1       data master write request
//  d_writedata      in   DATA_W  data master write data
//  d_byteenable     in   4       data master byte enables
//  d_readdata       out  DATA_W  data master read data
//  d_waitrequest    out  1       data master stall
//  m_address        out  ADDR_W  to slave
//  m_read           out  1       to slave
//  m_write          out  1       to slave
//  m_writedata      out  DATA_W  to slave
//  m_byteenable     out  4       to slave (4'b1111 for instr reads)
//  m_readdata       in   DATA_W  from slave
//  m_waitrequest    in   1       from slave
//  timeout_err      out  1       sticky: slave stalled > TIMEOUT cycles
// BEHAVIOUR
//  - FSM states: IDLE, GNT_I, GNT_D; state registered. Reset -> IDLE, timeout_err=0, wait counter=0.
//  - Outputs are combinational from state. In IDLE: m_read=m_write=0, m_address=0, m_byteenable=0,
//    i_waitrequest=d_waitrequest=1. Readdata outputs = m_readdata at all times (qualify by waitrequest).
//  - IDLE: next = GNT_D if d_req (d_read|d_write), else GNT_I if i_read; simultaneous -> data first.
//    Arbitration latency: 1 cycle from request to slave strobe.
//  - GNT_x: m_* driven from master x; x_waitrequest = m_waitrequest; other master waitrequest = 1.
//  - Completion = granted strobe high and m_waitrequest low. On completion: if other master
//    requesting -> grant it next cycle (back-to-back, no idle); else -> IDLE. Completing master's
//    own request that cycle is ignored for re-arbitration.
//  - Granted master drops all strobes before completion (protocol violation): -> IDLE next cycle.
//  - d_read and d_write both high: forwarded as-is; slave behaviour undefined; no arbiter check.
//  - Wait counter: counts cycles in GNT_x with m_waitrequest=1; clears on completion or IDLE;
//    saturates at TIMEOUT; reaching TIMEOUT sets timeout_err (sticky until reset). Grant unaffected.
//  - Async reset mid-transfer: immediate IDLE, slave strobes drop in same cycle; transfer lost.
// CONFIGURATION
//  ARB_ROUND_ROBIN_EN defined: 1-bit last_grant register (reset: instr). Simultaneous requests in
//    IDLE grant the master NOT last granted; last_grant updates on every completion.
//  Not defined: fixed data-master priority in IDLE as above; last_grant absent.
//  Completion-time handover to the other master is identical in both builds.
// TESTING
//  1 Reset: reset_n=0 mid GNT_D -> m_read=m_write=0, both waitrequest=1, timeout_err=0 immediately.
//  2 Single instr read: i_read, i_address=32'hBFC00000, slave waitrequest 1 cycle -> m_read high
//    one cycle after request, i_readdata = mem word in completion cycle, then IDLE.
//  3 Simultaneous i_read and d_write (32'hBFC00010, data 32'hDEADBEEF, be 4'b0011) -> data granted
//    first (both builds when last_grant=instr), instr granted in cycle after data completes.
//  4 Round robin (ARB_ROUND_ROBIN_EN): both request continuously -> grants alternate I,D,I,D;
//    without macro -> D each time d request present at IDLE.
//  5 Slave holds waitrequest=1 for 70 cycles -> timeout_err rises at cycle 64, stays high after
//    completion until reset_n.
//  6 Granted master drops d_read at cycle 2 while waitrequest=1 -> IDLE next cycle, m_read=0.

Source files
------------

// File: rtl/avalon_mem_arbiter.sv
// avalon_mem_arbiter: shares one Avalon-MM memory slave between the CPU instruction-fetch
// master (read-only) and the data master (read/write with byteenable).
// Optional build macro: ARB_ROUND_ROBIN_EN selects round-robin arbitration in IDLE instead of
// fixed data-master priority.
module avalon_mem_arbiter #(
   parameter int unsigned ADDR_W  = 32,
   parameter int unsigned DATA_W  = 32,
   parameter int unsigned TIMEOUT = 64
) (
   input  logic              clk,
   input  logic              reset_n,
   // instruction master
   input  logic [ADDR_W-1:0] i_address,
   input  logic              i_read,
   output logic [DATA_W-1:0] i_readdata,
   output logic              i_waitrequest,
   // data master
   input  logic [ADDR_W-1:0] d_address,
   input  logic              d_read,
   input  logic              d_write,
   input  logic [DATA_W-1:0] d_writedata,
   input  logic [3:0]        d_byteenable,
   output logic [DATA_W-1:0] d_readdata,
   output logic              d_waitrequest,
   // memory slave
   output logic [ADDR_W-1:0] m_address,
   output logic              m_read,
   output logic              m_write,
   output logic [DATA_W-1:0] m_writedata,
   output logic [3:0]        m_byteenable,
   input  logic [DATA_W-1:0] m_readdata,
   input  logic              m_waitrequest,
   // status
   output logic              timeout_err
);

   localparam int unsigned CntW = $clog2(TIMEOUT + 1);

   typedef enum logic [1:0] {
      StIdle,
      StGntI,
      StGntD
   } state_e;

   state_e            state_q, state_d;
   logic [CntW-1:0]   wait_cnt_q, wait_cnt_d;
   logic              timeout_err_q, timeout_err_d;

   logic d_req;
   logic gnt_strobe;
   logic done;

`ifdef ARB_ROUND_ROBIN_EN
   // 1 = data master was the last one to complete, 0 = instruction master
   logic last_grant_q, last_grant_d;
`endif

   assign d_req = d_read | d_write;

   // Strobe of whichever master currently owns the slave, and its completion
   always_comb begin
      gnt_strobe = 1'b0;
      unique case (state_q)
         StGntI:  gnt_strobe = i_read;
         StGntD:  gnt_strobe = d_req;
         default: gnt_strobe = 1'b0;
      endcase
      done = gnt_strobe & ~m_waitrequest;
   end

   // Arbitration and grant handover
   always_comb begin
      state_d = state_q;
      unique case (state_q)
         StIdle: begin
`ifdef ARB_ROUND_ROBIN_EN
            if (d_req && i_read) begin
               state_d = last_grant_q ? StGntI : StGntD;
            end else if (d_req) begin
               state_d = StGntD;
            end else if (i_read) begin
               state_d = StGntI;
            end
`else
            if (d_req) begin
               state_d = StGntD;
            end else if (i_read) begin
               state_d = StGntI;
            end
`endif
         end
         StGntI: begin
            if (!i_read) begin
               state_d = StIdle;
            end else if (!m_waitrequest) begin
               state_d = d_req ? StGntD : StIdle;
            end
         end
         StGntD: begin
            if (!d_req) begin
               state_d = StIdle;
            end else if (!m_waitrequest) begin
               state_d = i_read ? StGntI : StIdle;
            end
         end
         default: state_d = StIdle;
      endcase
   end

   // Stall counter saturates at TIMEOUT; the error flag is sticky
   always_comb begin
      wait_cnt_d = '0;
      if (state_q != StIdle && m_waitrequest) begin
         if (wait_cnt_q != CntW'(TIMEOUT)) begin
            wait_cnt_d = wait_cnt_q + CntW'(1);
         end else begin
            wait_cnt_d = wait_cnt_q;
         end
      end
      timeout_err_d = timeout_err_q | (wait_cnt_d == CntW'(TIMEOUT));
   end

`ifdef ARB_ROUND_ROBIN_EN
   // Remember which master completed most recently
   always_comb begin
      last_grant_d = last_grant_q;
      if (done) begin
         last_grant_d = (state_q == StGntD);
      end
   end
`endif

   // State registers
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q       <= StIdle;
         wait_cnt_q    <= '0;
         timeout_err_q <= 1'b0;
`ifdef ARB_ROUND_ROBIN_EN
         last_grant_q  <= 1'b0;
`endif
      end else begin
         state_q       <= state_d;
         wait_cnt_q    <= wait_cnt_d;
         timeout_err_q <= timeout_err_d;
`ifdef ARB_ROUND_ROBIN_EN
         last_grant_q  <= last_grant_d;
`endif
      end
   end

   // Slave-side mux and master stalls, decoded from the current grant only
   always_comb begin
      m_address     = '0;
      m_read        = 1'b0;
      m_write       = 1'b0;
      m_writedata   = '0;
      m_byteenable  = 4'b0000;
      i_waitrequest = 1'b1;
      d_waitrequest = 1'b1;
      unique case (state_q)
         StGntI: begin
            m_address     = i_address;
            m_read        = i_read;
            m_byteenable  = 4'b1111;
            i_waitrequest = m_waitrequest;
         end
         StGntD: begin
            m_address     = d_address;
            m_read        = d_read;
            m_write       = d_write;
            m_writedata   = d_writedata;
            m_byteenable  = d_byteenable;
            d_waitrequest = m_waitrequest;
         end
         default: ;
      endcase
   end

   // Read data is broadcast; each master qualifies it with its own waitrequest
   assign i_readdata  = m_readdata;
   assign d_readdata  = m_readdata;
   assign timeout_err = timeout_err_q;

endmodule
